mul_div_unit: RTL

- Iterative multiply/divide unit with architectural HI/LO registers.
- Parametrised multi-cycle successor to the single-cycle combinational ALU. It covers MULT/MULTU/DIV/DIVU/MTHI/MTLO.
- Sits beside the ALU in the EX stage. The pipeline stalls on busy.
- Radix-2: one iteration per clock, start/busy/done handshake, flush for exception abort.

---
 rtl/mul_div_unit_pkg.sv | 47 ++++
 rtl/mul_div_unit_sign_fix.sv | 28 ++
 rtl/mul_div_unit.sv | 250 +++++++++++++++++++++++++
 3 files changed

// File: rtl/mul_div_unit_pkg.sv
`default_nettype none
// ============================================================================
// Module      : mul_div_unit_pkg
// Description : Shared constants for the iterative multiply/divide unit.
//               Holds the default word width, the operation codes and the
//               state encodings, plus small helpers that classify an
//               operation code.
// Revision    : 1.0 - initial release
// ============================================================================
package mul_div_unit_pkg;

    // Default operand and HI/LO width
    localparam int WORD_WIDTH = 32;

    // Operation code type and encodings (codes 6 and 7 are reserved)
    typedef logic [2:0] md_op_t;

    localparam md_op_t MDOP_MULT  = 3'd0;
    localparam md_op_t MDOP_MULTU = 3'd1;
    localparam md_op_t MDOP_DIV   = 3'd2;
    localparam md_op_t MDOP_DIVU  = 3'd3;
    localparam md_op_t MDOP_MTHI  = 3'd4;
    localparam md_op_t MDOP_MTLO  = 3'd5;

    // Controller state encodings
    localparam logic [1:0] MD_IDLE = 2'd0;
    localparam logic [1:0] MD_BUSY = 2'd1;
    localparam logic [1:0] MD_DONE = 2'd2;

    // Operation treats its operands as two's-complement values
    function automatic logic md_is_signed(input md_op_t op);
        return (op == MDOP_MULT) || (op == MDOP_DIV);
    endfunction

    // Operation needs the multi-cycle datapath
    function automatic logic md_is_iter(input md_op_t op);
        return (op == MDOP_MULT) || (op == MDOP_MULTU) ||
               (op == MDOP_DIV)  || (op == MDOP_DIVU);
    endfunction

    // Operation selects the divider rather than the multiplier
    function automatic logic md_is_div(input md_op_t op);
        return (op == MDOP_DIV) || (op == MDOP_DIVU);
    endfunction

endpackage : mul_div_unit_pkg
`default_nettype wire

// File: rtl/mul_div_unit_sign_fix.sv
`default_nettype none
// ============================================================================
// Module      : md_sign_fix
// Description : Combinational conditional two's-complement negate. Used both
//               to turn signed operands into magnitudes and to re-apply the
//               result sign after the iterative core has finished.
// Ports       : val_i  - input value (W bits)
//               neg_i  - 1 = negate, 0 = pass through
//               val_o  - result (W bits)
// Revision    : 1.0 - initial release
// ============================================================================
module md_sign_fix #(
    parameter int W = 32
) (
    input  logic [W-1:0] val_i,
    input  logic         neg_i,
    output logic [W-1:0] val_o
);

    always_comb begin
        val_o = val_i;
        if (neg_i) begin
            val_o = ~val_i + W'(1);
        end
    end

endmodule : md_sign_fix
`default_nettype wire

// File: rtl/mul_div_unit.sv
`default_nettype none
// ============================================================================
// Module      : mul_div_unit
// Description : Radix-2 iterative multiply/divide unit with architectural
//               HI/LO registers. Executes MULT/MULTU/DIV/DIVU in WIDTH+2
//               clock edges (latch, WIDTH iterations, fix-up) and MTHI/MTLO
//               in a single edge. Signed operations run on magnitudes; the
//               result sign is re-applied in the fix-up cycle.
// Ports       : clk    - system clock, rising edge
//               rst    - asynchronous active-high reset
//               start  - operation request, sampled only while idle
//               mdOp   - operation code
//               src1   - multiplicand / dividend / MTHI-MTLO data
//               src2   - multiplier / divisor
//               flush  - abort in-flight operation, blocks start when idle
//               busy   - operation in progress
//               done   - one-cycle pulse when HI/LO written by mult/div
//               hi, lo - HI and LO registers
// Revision    : 1.0 - initial release
// ============================================================================
module mul_div_unit
    import mul_div_unit_pkg::*;
#(
    parameter int WIDTH = WORD_WIDTH
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             start,
    input  logic [2:0]       mdOp,
    input  logic [WIDTH-1:0] src1,
    input  logic [WIDTH-1:0] src2,
    input  logic             flush,
    output logic             busy,
    output logic             done,
    output logic [WIDTH-1:0] hi,
    output logic [WIDTH-1:0] lo
);

    localparam int CNT_W = $clog2(WIDTH) + 1;

    // ------------------------------------------------------------------
    // State
    // ------------------------------------------------------------------
    logic [1:0]       state_q,  state_d;
    logic [CNT_W-1:0] cnt_q,    cnt_d;
    logic [WIDTH-1:0] acc_hi_q, acc_hi_d;  // partial product high / remainder
    logic [WIDTH-1:0] acc_lo_q, acc_lo_d;  // multiplier shifting out / quotient shifting in
    logic [WIDTH-1:0] opb_q,    opb_d;     // multiplicand or divisor magnitude
    logic             is_div_q, is_div_d;
    logic             neg_lo_q, neg_lo_d;  // negate product (mult) or quotient (div)
    logic             neg_hi_q, neg_hi_d;  // negate remainder (div only)
    logic [WIDTH-1:0] hi_q,     hi_d;
    logic [WIDTH-1:0] lo_q,     lo_d;
    logic             done_q,   done_d;

    // ------------------------------------------------------------------
    // Operand magnitudes
    // ------------------------------------------------------------------
    logic             w_signed;
    logic             w_a_neg;
    logic             w_b_neg;
    logic             w_b_zero;
    logic [WIDTH-1:0] w_a_mag;
    logic [WIDTH-1:0] w_b_mag;

    assign w_signed = md_is_signed(mdOp);
    assign w_a_neg  = w_signed & src1[WIDTH-1];
    assign w_b_neg  = w_signed & src2[WIDTH-1];
    assign w_b_zero = (src2 == '0);

    md_sign_fix #(.W(WIDTH)) u_mag_a (
        .val_i (src1),
        .neg_i (w_a_neg),
        .val_o (w_a_mag)
    );

    md_sign_fix #(.W(WIDTH)) u_mag_b (
        .val_i (src2),
        .neg_i (w_b_neg),
        .val_o (w_b_mag)
    );

    // ------------------------------------------------------------------
    // Iteration datapath
    // ------------------------------------------------------------------
    // Shift-add: add the multiplicand when the current multiplier bit is set,
    // then shift the {carry, acc_hi, acc_lo} chain right by one.
    logic [WIDTH:0]   w_mul_sum;
    assign w_mul_sum = {1'b0, acc_hi_q} + (acc_lo_q[0] ? {1'b0, opb_q} : '0);

    // Restoring divide: shift the next dividend bit into the remainder and
    // trial-subtract the divisor. Bit WIDTH of the difference is the borrow,
    // since the shifted remainder is always below twice the divisor.
    logic [WIDTH:0]   w_div_shift;
    logic [WIDTH:0]   w_div_diff;
    logic             w_div_ok;
    assign w_div_shift = {acc_hi_q, acc_lo_q[WIDTH-1]};
    assign w_div_diff  = w_div_shift - {1'b0, opb_q};
    assign w_div_ok    = ~w_div_diff[WIDTH];

    // ------------------------------------------------------------------
    // Result sign fix-up
    // ------------------------------------------------------------------
    logic [2*WIDTH-1:0] w_prod_fix;
    logic [WIDTH-1:0]   w_quo_fix;
    logic [WIDTH-1:0]   w_rem_fix;

    md_sign_fix #(.W(2*WIDTH)) u_fix_prod (
        .val_i ({acc_hi_q, acc_lo_q}),
        .neg_i (neg_lo_q),
        .val_o (w_prod_fix)
    );

    md_sign_fix #(.W(WIDTH)) u_fix_quo (
        .val_i (acc_lo_q),
        .neg_i (neg_lo_q),
        .val_o (w_quo_fix)
    );

    md_sign_fix #(.W(WIDTH)) u_fix_rem (
        .val_i (acc_hi_q),
        .neg_i (neg_hi_q),
        .val_o (w_rem_fix)
    );

    // ------------------------------------------------------------------
    // Next-state logic
    // ------------------------------------------------------------------
    always_comb begin
        state_d  = state_q;
        cnt_d    = cnt_q;
        acc_hi_d = acc_hi_q;
        acc_lo_d = acc_lo_q;
        opb_d    = opb_q;
        is_div_d = is_div_q;
        neg_lo_d = neg_lo_q;
        neg_hi_d = neg_hi_q;
        hi_d     = hi_q;
        lo_d     = lo_q;
        done_d   = 1'b0;

        case (state_q)
            MD_IDLE: begin
                // flush has priority over any request while idle
                if (start && !flush) begin
                    if (md_is_iter(mdOp)) begin
                        state_d  = MD_BUSY;
                        cnt_d    = '0;
                        acc_hi_d = '0;
                        acc_lo_d = w_a_mag;
                        opb_d    = w_b_mag;
                        is_div_d = md_is_div(mdOp);
                        // A zero divisor must yield an all-ones quotient
                        // regardless of the dividend sign, so the quotient
                        // negate is suppressed. The remainder still carries
                        // the dividend sign, which reproduces src1 exactly.
                        neg_lo_d = (w_a_neg ^ w_b_neg) &
                                   ~(md_is_div(mdOp) & w_b_zero);
                        neg_hi_d = md_is_div(mdOp) & w_a_neg;
                    end else if (mdOp == MDOP_MTHI) begin
                        hi_d = src1;
                    end else if (mdOp == MDOP_MTLO) begin
                        lo_d = src1;
                    end
                end
            end

            MD_BUSY: begin
                if (flush) begin
                    state_d = MD_IDLE;
                    cnt_d   = '0;
                end else begin
                    if (is_div_q) begin
                        acc_hi_d = w_div_ok ? w_div_diff[WIDTH-1:0]
                                            : w_div_shift[WIDTH-1:0];
                        acc_lo_d = {acc_lo_q[WIDTH-2:0], w_div_ok};
                    end else begin
                        acc_hi_d = w_mul_sum[WIDTH:1];
                        acc_lo_d = {w_mul_sum[0], acc_lo_q[WIDTH-1:1]};
                    end
                    cnt_d = cnt_q + CNT_W'(1);
                    if (cnt_q == CNT_W'(WIDTH - 1)) begin
                        state_d = MD_DONE;
                    end
                end
            end

            MD_DONE: begin
                state_d = MD_IDLE;
                cnt_d   = '0;
                if (!flush) begin
                    done_d = 1'b1;
                    if (is_div_q) begin
                        hi_d = w_rem_fix;
                        lo_d = w_quo_fix;
                    end else begin
                        hi_d = w_prod_fix[2*WIDTH-1:WIDTH];
                        lo_d = w_prod_fix[WIDTH-1:0];
                    end
                end
            end

            default: begin
                state_d = MD_IDLE;
                cnt_d   = '0;
            end
        endcase
    end

    // ------------------------------------------------------------------
    // Registers
    // ------------------------------------------------------------------
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q  <= MD_IDLE;
            cnt_q    <= '0;
            acc_hi_q <= '0;
            acc_lo_q <= '0;
            opb_q    <= '0;
            is_div_q <= 1'b0;
            neg_lo_q <= 1'b0;
            neg_hi_q <= 1'b0;
            hi_q     <= '0;
            lo_q     <= '0;
            done_q   <= 1'b0;
        end else begin
            state_q  <= state_d;
            cnt_q    <= cnt_d;
            acc_hi_q <= acc_hi_d;
            acc_lo_q <= acc_lo_d;
            opb_q    <= opb_d;
            is_div_q <= is_div_d;
            neg_lo_q <= neg_lo_d;
            neg_hi_q <= neg_hi_d;
            hi_q     <= hi_d;
            lo_q     <= lo_d;
            done_q   <= done_d;
        end
    end

    // ------------------------------------------------------------------
    // Outputs
    // ------------------------------------------------------------------
    assign busy = (state_q != MD_IDLE);
    assign done = done_q;
    assign hi   = hi_q;
    assign lo   = lo_q;

endmodule : mul_div_unit
`default_nettype wire
